// File: rtl/rca_lsq.sv
// In-order load/store queue between the RCA memory OUs and a word-addressed data port.
// One access in flight; load results come back sign/zero-extended and registered.
module rca_lsq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_request,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
  } entry_t;

  typedef enum logic {REQ, WAIT_RD} state_e;

  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  state_e           state_q, state_d;

  entry_t           head;
  logic             empty, enq, pop, ld_done;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [XLEN-1:0]  wdata, shifted, fmt;

  assign head     = fifo_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign lsq_full = (count_q == CNT_W'(DEPTH));
  assign enq      = new_request && !lsq_full && (load ^ store);

  // Access sequencing: one outstanding access, loads pop only when data returns
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    ld_done     = 1'b0;
    mem_request = 1'b0;
    case (state_q)
      REQ: begin
        mem_request = !empty;
        if (!empty && mem_ack) begin
          if (head.load) state_d = WAIT_RD;
          else           pop     = 1'b1;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          pop     = 1'b1;
          ld_done = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // Lane selection; halfword and word offsets are forced aligned
  always_comb begin
    off   = head.addr[1:0];
    be    = 4'b1111;
    wdata = head.data;
    case (head.fn3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = XLEN'({4{head.data[7:0]}});
      end
      2'b01: begin
        off   = {head.addr[1], 1'b0};
        be    = 4'b0011 << off;
        wdata = XLEN'({2{head.data[15:0]}});
      end
      default: begin
        off   = 2'b00;
        be    = 4'b1111;
        wdata = head.data;
      end
    endcase
  end

  assign mem_addr  = empty ? '0 : {head.addr[XLEN-1:2], 2'b00};
  assign mem_be    = empty ? '0 : be;
  assign mem_wdata = empty ? '0 : wdata;
  assign mem_we    = !empty && !head.load;

  // Load result extraction and extension
  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    case (head.fn3)
      3'b000:  fmt = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  fmt = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  fmt = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  fmt = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: fmt = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= REQ;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      load_data     <= '0;
      load_complete <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      load_complete <= ld_done;
      if (ld_done) load_data <= fmt;
      if (enq) begin
        fifo_q[wr_ptr_q] <= '{addr: addr, data: data, fn3: fn3, load: load};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_lsq.sv
// Directed bench for rca_lsq: single-access vector table plus fill, ordering and reset sequences.
module tb_rca_lsq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data, load_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fn3;
  logic        load, store, new_request, lsq_full, load_complete;
  logic [3:0]  mem_be;
  logic        mem_we, mem_request, mem_ack, mem_rvalid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rca_lsq #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3), .load(load),
    .store(store), .new_request(new_request), .lsq_full(lsq_full),
    .load_data(load_data), .load_complete(load_complete), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_request(mem_request), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    new_request = 1'b1;
    load        = ld;
    store       = !ld;
    fn3         = f3;
    addr        = a;
    data        = d;
  endtask

  task automatic idle_req();
    new_request = 1'b0;
    load        = 1'b0;
    store       = 1'b0;
  endtask

  // One request through an empty queue with minimum memory latency
  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    drive_req(v.ld, v.f3, v.a, v.d);
    #1 check($sformatf("v%0d_full", i), 32'(lsq_full), 32'd0);
    @(negedge clk);
    idle_req();
    mem_ack = 1'b1;
    #1;
    check($sformatf("v%0d_req", i), 32'(mem_request), 32'd1);
    check($sformatf("v%0d_addr", i), mem_addr, v.maddr);
    check($sformatf("v%0d_be", i), 32'(mem_be), 32'(v.be));
    check($sformatf("v%0d_we", i), 32'(mem_we), 32'(!v.ld));
    if (!v.ld) check($sformatf("v%0d_wdata", i), mem_wdata, v.wdata);
    @(negedge clk);
    mem_ack = 1'b0;
    if (v.ld) begin
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      #1 check($sformatf("v%0d_req_wait", i), 32'(mem_request), 32'd0);
      check($sformatf("v%0d_lc_early", i), 32'(load_complete), 32'd0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      check($sformatf("v%0d_lc", i), 32'(load_complete), 32'd1);
      check($sformatf("v%0d_ldata", i), load_data, v.ldata);
      @(negedge clk);
      #1 check($sformatf("v%0d_lc_pulse", i), 32'(load_complete), 32'd0);
    end else begin
      #1 check($sformatf("v%0d_req_done", i), 32'(mem_request), 32'd0);
    end
  endtask

  initial begin
    //            ld    f3      addr          data          rdata         be       maddr         wdata         ldata
    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b1, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_0000, 4'b1100, 32'h0000_0100, 32'h0,        32'h0000_80FF};
    vecs[4]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0000, 4'b1100, 32'h0000_0100, 32'h0,        32'hFFFF_80FF};
    vecs[5]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 4'b0010, 32'h0000_0100, 32'h0,        32'h0000_007F};
    vecs[6]  = '{1'b0, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'h0,       4'b0010, 32'h0000_0200, 32'h7878_7878, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0,       4'b1100, 32'h0000_0200, 32'h5678_5678, 32'h0};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_030C, 32'hCAFE_F00D, 32'h0,       4'b1111, 32'h0000_030C, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0103, 32'h0,        32'h1122_3344, 4'b1111, 32'h0000_0100, 32'h0,        32'h1122_3344};
    vecs[10] = '{1'b1, 3'b011, 32'h0000_0002, 32'h0,        32'hA5A5_A5A5, 4'b1111, 32'h0000_0000, 32'h0,        32'hA5A5_A5A5};

    rst = 1'b0;
    idle_req();
    addr = '0; data = '0; fn3 = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_full", 32'(lsq_full), 32'd0);
    check("rst_lc", 32'(load_complete), 32'd0);
    check("rst_ldata", load_data, 32'd0);
    check("rst_req", 32'(mem_request), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Dropped request: load and store both set
    @(negedge clk);
    drive_req(1'b1, 3'b010, 32'h0000_0700, 32'h0);
    store = 1'b1;
    @(negedge clk);
    idle_req();
    #1 check("drop_req", 32'(mem_request), 32'd0);

    // Fill with ack held low, then drain at one store per cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_req(1'b0, 3'b010, 32'h0000_0400 + 32'(4 * i), 32'(i));
      #1 check($sformatf("fill%0d_full", i), 32'(lsq_full), 32'd0);
    end
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0410, 32'h4);
    #1;
    check("full_rise", 32'(lsq_full), 32'd1);
    check("full_head", mem_addr, 32'h0000_0400);
    @(negedge clk);
    mem_ack = 1'b1;
    #1 check("full_hold", 32'(lsq_full), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("full_fall", 32'(lsq_full), 32'd0);
    check("full_head2", mem_addr, 32'h0000_0404);
    @(negedge clk);
    idle_req();
    mem_ack = 1'b1;
    #1 check("full_again", 32'(lsq_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("drain%0d_req", i), 32'(mem_request), 32'd1);
      check($sformatf("drain%0d_addr", i), mem_addr, 32'h0000_0404 + 32'(4 * i));
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("drain_empty", 32'(mem_request), 32'd0);
    check("drain_full", 32'(lsq_full), 32'd0);

    // Store queued behind a slow load must wait for the load to pop
    @(negedge clk);
    drive_req(1'b1, 3'b010, 32'h0000_0500, 32'h0);
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0504, 32'h5555_AAAA);
    mem_ack = 1'b1;
    #1 check("ord_ld_addr", mem_addr, 32'h0000_0500);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      idle_req();
      mem_ack = 1'b0;
      if (i == 6) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
      end
      #1 check($sformatf("ord_wait%0d", i), 32'(mem_request), 32'd0);
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_ack    = 1'b1;
    #1;
    check("ord_lc", 32'(load_complete), 32'd1);
    check("ord_ldata", load_data, 32'h0BAD_F00D);
    check("ord_st_req", 32'(mem_request), 32'd1);
    check("ord_st_addr", mem_addr, 32'h0000_0504);
    check("ord_st_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("ord_lc_pulse", 32'(load_complete), 32'd0);
    check("ord_ldata_hold", load_data, 32'h0BAD_F00D);
    check("ord_idle", 32'(mem_request), 32'd0);

    // Reset while a load is outstanding discards it
    @(negedge clk);
    drive_req(1'b1, 3'b010, 32'h0000_0600, 32'h0);
    @(negedge clk);
    idle_req();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    rst     = 1'b0;
    #1 check("rwait_req", 32'(mem_request), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check("rwait_lc", 32'(load_complete), 32'd0);
    check("rwait_ldata", load_data, 32'd0);
    check("rwait_full", 32'(lsq_full), 32'd0);
    check("rwait_req2", 32'(mem_request), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rca_lsq.md
# rca_lsq

Load/store queue for the reconfigurable accelerator's memory-access operation units. It sits directly downstream of the RCA load/store OUs and accepts their requests (address, store data, fn3, load/store flag) into an in-order FIFO. It issues the requests one at a time to a word-addressed data-memory port and returns sign- or zero-extended load results to the OU. At most one memory access is in flight.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- XLEN, 32, from taiga_config; datapath width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- addr  in  XLEN  OU request byte address.
- data  in  XLEN  OU store data, taken from the low bits.
- fn3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- load  in  1  request is a load.
- store  in  1  request is a store.
- new_request  in  1  request valid.
- lsq_full  out  1  queue cannot accept a request this cycle.
- load_data  out  XLEN  extended load result.
- load_complete  out  1  one-cycle pulse; load_data valid.
- mem_addr  out  XLEN  word address: {head addr[XLEN-1:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_we  out  1  head entry is a store.
- mem_request  out  1  access valid.
- mem_ack  in  1  memory accepted the access this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read word.

## Operation
- Enqueue:
  - Condition: new_request && !lsq_full && (load ^ store).
  - Stored fields: addr, data, fn3, load.
  - A request with load == store is dropped silently.
  - A request while full is ignored. The OU must hold it.
- lsq_full = (count == DEPTH), from registered count.
  - No same-cycle enqueue into a slot freed by a pop while full.
- Simultaneous enqueue and pop: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH.
- FSM states: REQ, WAIT_RD.
  - REQ:
    - mem_request = !empty; all mem_* fields are driven from the head entry.
    - On mem_ack with a store: pop; stay in REQ.
    - On mem_ack with a load: go to WAIT_RD; do not pop yet.
  - WAIT_RD:
    - mem_request = 0.
    - On mem_rvalid: pop, register the formatted result, return to REQ.
  - mem_rvalid is ignored in REQ.
- Lane select uses off = addr[1:0], forced aligned:
  - W: off = 0.
  - H/HU: off[0] = 0.
  - Misaligned accesses are not supported.
- mem_be:
  - B: 0001 << off.
  - H: 0011 << off.
  - W: 1111.
  - Loads also drive mem_be.
- mem_wdata:
  - B: {4{data[7:0]}}.
  - H: {2{data[15:0]}}.
  - W: data.
- Load formatting: r = mem_rdata >> (8*off).
  - LB: sign-extend r[7:0].
  - LBU: zero-extend r[7:0].
  - LH: sign-extend r[15:0].
  - LHU: zero-extend r[15:0].
  - LW: r.
  - Any other fn3: treated as LW.
- Requests complete strictly in enqueue order. Stores never bypass an outstanding load.

## Timing
- Reset values:
  - All outputs 0; lsq_full 0.
  - FIFO empty; FSM in REQ.
  - Any outstanding load is discarded.
  - A mem_rvalid arriving after reset produces no load_complete.
- Enqueue in cycle N makes the entry visible at head in cycle N+1. mem_request is asserted in N+1 if the queue was empty.
- mem_request holds with stable fields until mem_ack.
- Store: done at the mem_ack edge. The next entry may be requested the following cycle.
- Load:
  - Ack at cycle A; mem_rvalid at cycle ≥ A+1.
  - load_complete is registered and high exactly one cycle, the cycle after mem_rvalid.
  - load_data holds its value until the next load_complete.
- Minimum load latency: new_request in cycle 0 → load_complete in cycle 3 (ack cycle 1, rvalid cycle 2).
- Store throughput with mem_ack always high: one per cycle.

## Test plan
- Reset deassert, LW at addr 0x100; memory returns 0xDEADBEEF with mem_ack in cycle 1 and mem_rvalid in cycle 2 → mem_addr 0x100, mem_be 1111, mem_we 0; load_complete only in cycle 3 with load_data 0xDEADBEEF.
- LB at 0x103 with rdata 0x80FF_0000 → mem_be 1000 in the request; load_data 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB data 0x12345678 at 0x201 → mem_addr 0x200, mem_be 0010, mem_wdata 0x78787878, mem_we 1. SH at 0x202 → mem_be 1100, mem_wdata 0x56785678.
- With mem_ack held low, enqueue DEPTH=4 stores → lsq_full rises the cycle after the 4th enqueue. A 5th new_request is not accepted. One mem_ack → lsq_full falls the next cycle; the 5th request enqueues then. Order of mem_addr matches enqueue order.
- LW queued ahead of an SW with mem_rvalid delayed 5 cycles → the SW mem_request appears only the cycle after load pop.
- Assert rst during WAIT_RD, then pulse mem_rvalid after release → no load_complete; lsq_full 0; mem_request 0.
